// File: rtl/prog_freq_divider.sv
// Runtime-programmable integer clock divider, 50% duty for even and odd N.
// Divisor changes are deferred to period boundaries so clk_out never runts.
module prog_freq_divider #(
  parameter int WIDTH       = 4,
  parameter int DEFAULT_DIV = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] div,
  output logic             clk_out,
  output logic [WIDTH-1:0] pos_count,
  output logic [WIDTH-1:0] neg_count,
  output logic             tick,
  output logic [WIDTH-1:0] div_active,
  output logic             err
);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  localparam logic [WIDTH-1:0] DEF = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] MIN = WIDTH'(2);

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] cnt_nx;
  logic [WIDTH-1:0] act_nx;
  logic [WIDTH-1:0] pending;
  logic [WIDTH-1:0] pend_nx;
  logic [WIDTH-1:0] half;
  logic             pend_valid;
  logic             pv_nx;
  logic             p_out;
  logic             p_nx;
  logic             n_out;
  logic             tick_nx;
  logic             err_nx;
  logic             wrap;
  logic             start;
  logic             apply;

  assign half = div_active >> 1;
  assign wrap = (pos_count == div_active - 1'b1);

  always_comb begin
    state_nx = state;
    cnt_nx   = pos_count;
    act_nx   = div_active;
    pend_nx  = pending;
    pv_nx    = pend_valid;
    err_nx   = err;
    p_nx     = 1'b0;
    tick_nx  = 1'b0;
    start    = 1'b0;
    apply    = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_nx = '0;
        if (en) begin
          state_nx = RUN;
          start    = 1'b1;
          apply    = 1'b1;
        end
      end
      RUN: begin
        if (wrap) begin
          cnt_nx = '0;
          apply  = 1'b1;
          if (en) start = 1'b1;
          else state_nx = IDLE;
        end else begin
          cnt_nx = pos_count + 1'b1;
          p_nx   = (cnt_nx < half);
        end
      end
      default: state_nx = IDLE;
    endcase
    // A fresh period always opens high since H >= 1 for every legal N.
    if (start) begin
      tick_nx = 1'b1;
      p_nx    = 1'b1;
    end
    if (apply && pend_valid) begin
      act_nx = pending;
      pv_nx  = 1'b0;
    end
    // A load on the boundary edge lands in pending for the next boundary.
    if (load) begin
      if (div >= MIN) begin
        pend_nx = div;
        pv_nx   = 1'b1;
      end else begin
        err_nx = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      pos_count  <= '0;
      p_out      <= 1'b0;
      tick       <= 1'b0;
      div_active <= DEF;
      pending    <= DEF;
      pend_valid <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_nx;
      pos_count  <= cnt_nx;
      p_out      <= p_nx;
      tick       <= tick_nx;
      div_active <= act_nx;
      pending    <= pend_nx;
      pend_valid <= pv_nx;
      err        <= err_nx;
    end
  end

  // Half-cycle stretch only matters for odd ratios.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      n_out     <= 1'b0;
      neg_count <= '0;
    end else begin
      n_out     <= div_active[0] & p_out;
      neg_count <= pos_count;
    end
  end

  assign clk_out = p_out | n_out;

endmodule

// File: tb/tb_prog_freq_divider.sv
// Directed bench for prog_freq_divider.
// Checks waveform shape per half-cycle, reloads, err and async reset.
module tb_prog_freq_divider;

  logic       clk;
  logic       reset;
  logic       en;
  logic       load;
  logic [3:0] div;
  logic       clk_out;
  logic [3:0] pos_count;
  logic [3:0] neg_count;
  logic       tick;
  logic [3:0] div_active;
  logic       err;

  int n_cmp = 0;
  int n_bad = 0;

  prog_freq_divider #(
    .WIDTH(4),
    .DEFAULT_DIV(3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .load      (load),
    .div       (div),
    .clk_out   (clk_out),
    .pos_count (pos_count),
    .neg_count (neg_count),
    .tick      (tick),
    .div_active(div_active),
    .err       (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One full output period of ratio n, sampled after every clock edge.
  task automatic watch(input int n, input string tag);
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      chk({tag, "_pos"}, 32'(pos_count), c);
      chk({tag, "_tick"}, 32'(tick), 32'(c == 0));
      chk({tag, "_act"}, 32'(div_active), n);
      chk({tag, "_hi_p"}, 32'(clk_out), 32'(2 * c < n));
      @(negedge clk); #1;
      chk({tag, "_hi_n"}, 32'(clk_out), 32'(2 * c + 1 < n));
      chk({tag, "_neg"}, 32'(neg_count), c);
    end
  endtask

  task automatic idle_chk(input string tag);
    @(posedge clk); #1;
    chk({tag, "_pos"}, 32'(pos_count), 0);
    chk({tag, "_tick"}, 32'(tick), 0);
    chk({tag, "_clk"}, 32'(clk_out), 0);
    @(negedge clk); #1;
    chk({tag, "_clkn"}, 32'(clk_out), 0);
  endtask

  initial begin
    reset = 1'b0;
    en    = 1'b0;
    load  = 1'b0;
    div   = '0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pos", 32'(pos_count), 0);
    chk("rst_neg", 32'(neg_count), 0);
    chk("rst_clk", 32'(clk_out), 0);
    chk("rst_tick", 32'(tick), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_act", 32'(div_active), 3);
    reset = 1'b1;
    idle_chk("idle0");

    // default ratio 3
    en = 1'b1;
    watch(3, "n3a");
    watch(3, "n3b");
    en = 1'b0;
    idle_chk("idle1");

    // load 6 while idle
    load = 1'b1;
    div  = 4'd6;
    @(posedge clk); #1;
    load = 1'b0;
    chk("pend_only", 32'(div_active), 3);
    en = 1'b1;
    watch(6, "n6a");

    // load coinciding with the wrap edge: old value applies first
    load = 1'b1;
    div  = 4'd7;
    fork
      begin
        @(posedge clk); #2;
        load = 1'b0;
      end
    join_none
    watch(6, "n6b");
    watch(7, "n7a");

    // mid-period load of 4 while pos_count==3
    fork
      begin
        repeat (4) @(posedge clk);
        #2;
        load = 1'b1;
        div  = 4'd4;
        @(posedge clk); #2;
        load = 1'b0;
      end
    join_none
    watch(7, "n7b");
    watch(4, "n4a");

    // move to ratio 5
    fork
      begin
        @(posedge clk); #2;
        load = 1'b1;
        div  = 4'd5;
        @(posedge clk); #2;
        load = 1'b0;
      end
    join_none
    watch(4, "n4b");
    watch(5, "n5a");
    chk("err_pre", 32'(err), 0);

    // illegal ratio 1 while running
    fork
      begin
        @(posedge clk); #2;
        load = 1'b1;
        div  = 4'd1;
        @(posedge clk); #2;
        load = 1'b0;
      end
    join_none
    watch(5, "n5b");
    chk("err_set", 32'(err), 1);
    watch(5, "n5c");
    chk("err_stick", 32'(err), 1);

    // drop en at pos_count==2: period completes, then idle
    fork
      begin
        repeat (3) @(posedge clk);
        #2;
        en = 1'b0;
      end
    join_none
    watch(5, "n5d");
    idle_chk("idle2");
    idle_chk("idle3");

    // async reset mid-period at N=7 while clk_out high
    load = 1'b1;
    div  = 4'd7;
    @(posedge clk); #1;
    load = 1'b0;
    en   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_pos", 32'(pos_count), 2);
    chk("pre_rst_clk", 32'(clk_out), 1);
    chk("pre_rst_act", 32'(div_active), 7);
    #1;
    reset = 1'b0;
    #1;
    chk("arst_clk", 32'(clk_out), 0);
    chk("arst_pos", 32'(pos_count), 0);
    chk("arst_neg", 32'(neg_count), 0);
    chk("arst_act", 32'(div_active), 3);
    chk("arst_err", 32'(err), 0);
    @(negedge clk); #1;
    chk("arst_hold", 32'(clk_out), 0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rel_tick", 32'(tick), 1);
    chk("rel_pos", 32'(pos_count), 0);
    chk("rel_clk", 32'(clk_out), 1);
    @(posedge clk); #1;
    chk("rel_tick1", 32'(tick), 0);
    chk("rel_pos1", 32'(pos_count), 1);
    chk("rel_clk1", 32'(clk_out), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
